// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port data RAM between the Hack CPU and a
// host port. The CPU normally owns the RAM. The host gets the RAM when the
// CPU is idle on memory, or after it has been blocked for MAX_WAIT busy
// cycles. A host grant lasts at most BURST_MAX accesses. It is followed by
// one DRAIN cycle, so the host's last read data never reaches the CPU as
// valid inM.
module ram_arbiter #(
  parameter int unsigned MAX_WAIT  = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [14:0] host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_gnt,
  output logic [15:0] host_rdata,
  output logic        host_rvalid,
  output logic [14:0] ram_addr,
  output logic        ram_wr,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout
);

  typedef enum logic [1:0] {
    CPU_OWN  = 2'd0,
    HOST_OWN = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);
  localparam logic [7:0] BURST_MAX_C = 8'(BURST_MAX);

  state_t      state_r;
  logic [7:0]  wait_cnt_r;
  logic [7:0]  burst_cnt_r;
  logic        cpu_stall_r;
  logic        host_rvalid_r;
  logic [15:0] host_rdata_r;

  logic        host_gnt_s;
  logic [14:0] ram_addr_s;
  logic        ram_wr_s;
  logic [15:0] ram_din_s;
  logic [8:0]  burst_next_s;
  logic        force_host_s;

  // Count of host accesses including the one granted this cycle.
  assign burst_next_s = {1'b0, burst_cnt_r} + 9'd1;

  // The host gets in when the CPU is idle or once it has waited long enough.
  assign force_host_s = host_req & (~cpu_req | (wait_cnt_r >= MAX_WAIT_C));

  // RAM port mux and host grant, selected by the current owner.
  always_comb begin
    host_gnt_s = 1'b0;
    ram_addr_s = cpu_addr;
    ram_wr_s   = 1'b0;
    ram_din_s  = cpu_wdata;
    case (state_r)
      CPU_OWN: begin
        host_gnt_s = 1'b0;
        ram_addr_s = cpu_addr;
        ram_wr_s   = cpu_wr & cpu_req;
        ram_din_s  = cpu_wdata;
      end
      HOST_OWN: begin
        host_gnt_s = host_req;
        ram_addr_s = host_addr;
        ram_wr_s   = host_wr & host_req;
        ram_din_s  = host_wdata;
      end
      DRAIN: begin
        // The stalled CPU must not reach the RAM. Its address only
        // produces a harmless read.
        host_gnt_s = 1'b0;
        ram_addr_s = cpu_addr;
        ram_wr_s   = 1'b0;
        ram_din_s  = cpu_wdata;
      end
      default: begin
        host_gnt_s = 1'b0;
        ram_addr_s = cpu_addr;
        ram_wr_s   = 1'b0;
        ram_din_s  = cpu_wdata;
      end
    endcase
  end

  // Ownership FSM with the wait and burst counters and the registered CPU stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= CPU_OWN;
      wait_cnt_r  <= 8'd0;
      burst_cnt_r <= 8'd0;
      cpu_stall_r <= 1'b0;
    end else begin
      case (state_r)
        CPU_OWN: begin
          if (force_host_s) begin
            // The CPU access in this deciding cycle still completes.
            state_r     <= HOST_OWN;
            wait_cnt_r  <= 8'd0;
            burst_cnt_r <= 8'd0;
            cpu_stall_r <= 1'b1;
          end else begin
            state_r     <= CPU_OWN;
            burst_cnt_r <= 8'd0;
            cpu_stall_r <= 1'b0;
            if (host_req && cpu_req) begin
              if (wait_cnt_r == 8'hFF) begin
                wait_cnt_r <= wait_cnt_r;
              end else begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
              end
            end else begin
              wait_cnt_r <= 8'd0;
            end
          end
        end
        HOST_OWN: begin
          wait_cnt_r  <= 8'd0;
          cpu_stall_r <= 1'b1;
          if (!host_req) begin
            state_r     <= DRAIN;
            burst_cnt_r <= burst_cnt_r;
          end else if (burst_next_s == {1'b0, BURST_MAX_C}) begin
            state_r     <= DRAIN;
            burst_cnt_r <= burst_next_s[7:0];
          end else begin
            state_r     <= HOST_OWN;
            burst_cnt_r <= burst_next_s[7:0];
          end
        end
        DRAIN: begin
          state_r     <= CPU_OWN;
          wait_cnt_r  <= 8'd0;
          burst_cnt_r <= 8'd0;
          cpu_stall_r <= 1'b0;
        end
        default: begin
          state_r     <= CPU_OWN;
          wait_cnt_r  <= 8'd0;
          burst_cnt_r <= 8'd0;
          cpu_stall_r <= 1'b0;
        end
      endcase
    end
  end

  // Host read return: flag the cycle after each granted read and keep the last word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_rvalid_r <= 1'b0;
      host_rdata_r  <= 16'd0;
    end else begin
      host_rvalid_r <= host_gnt_s & ~host_wr;
      if (host_rvalid_r) begin
        host_rdata_r <= ram_dout;
      end else begin
        host_rdata_r <= host_rdata_r;
      end
    end
  end

  // ram_dout is the RAM's output register. While host_rvalid is high, the
  // host reads that register directly. Otherwise it sees the last word held.
  assign host_rdata  = host_rvalid_r ? ram_dout : host_rdata_r;
  assign host_rvalid = host_rvalid_r;
  assign host_gnt    = host_gnt_s;
  assign cpu_stall   = cpu_stall_r;
  assign cpu_rdata   = ram_dout;
  assign ram_addr    = ram_addr_s;
  assign ram_din     = ram_din_s;
  // The write strobe is blocked while reset is held.
  assign ram_wr      = reset ? ram_wr_s : 1'b0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter. It has a behavioural RAM and runs a vector table,
// directed multi-cycle sequences, and a randomized run checked against a
// transaction-level reference model.
module tb_ram_arbiter;

  localparam int MAX_WAIT  = 8;
  localparam int BURST_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wr;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        host_req, host_wr;
  logic [14:0] host_addr;
  logic [15:0] host_wdata;
  logic        host_gnt, host_rvalid;
  logic [15:0] host_rdata;
  logic [14:0] ram_addr;
  logic        ram_wr;
  logic [15:0] ram_din, ram_dout;

  always #5 clk = ~clk;

  ram_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Behavioural single-port RAM (sync read, read-first) with a bench backdoor.
  logic [15:0] mem [0:32767];
  logic [15:0] dout_q;
  logic        poke_en = 1'b0;
  logic [14:0] poke_addr = 15'd0;
  logic [15:0] poke_data = 16'd0;
  assign ram_dout = dout_q;
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_din;
    if (poke_en) mem[poke_addr] <= poke_data;
    dout_q <= mem[ram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [14:0] a, input logic [15:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 15'd0; cpu_wdata = 16'd0;
    host_req = 1'b0; host_wr = 1'b0; host_addr = 15'd0; host_wdata = 16'd0;
  endtask

  typedef struct {
    logic        c_req;
    logic        c_wr;
    logic [14:0] c_addr;
    logic [15:0] c_wdata;
    logic        h_req;
    logic [14:0] e_addr;
    logic        e_wr;
    logic [15:0] e_din;
    logic        e_stall;
    logic        e_gnt;
  } vec_t;

  vec_t vecs [6];

  // Reference model state for the randomized run
  logic [15:0] shadow [0:15];
  int          m_owner;     // 0 cpu, 1 host, 2 drain
  int          m_blocked;   // busy cycles the host has waited
  int          m_used;      // host accesses in this grant
  logic        m_rv, m_cpu_v;
  logic [15:0] m_rd, m_cpu_d;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first;
    int          grants;
    logic        gap;
    logic [15:0] got [$];
    logic [14:0] k;
    logic        last_gnt;
    logic        busy;
    logic        e_wr;

    // ---------------- reset state ----------------
    idle_inputs();
    reset = 1'b0;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 15'd77; cpu_wdata = 16'hDEAD;
    tick(); tick();
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_gnt", host_gnt, 1'b0);
    check("rst_rvalid", host_rvalid, 1'b0);
    check("rst_rdata", host_rdata, 16'd0);
    check("rst_ram_wr", ram_wr, 1'b0);
    idle_inputs();
    reset = 1'b1;
    tick();

    // ---------------- vector table: CPU ownership mux ----------------
    vecs[0] = '{1'b1, 1'b1, 15'h0010, 16'hAAAA, 1'b0, 15'h0010, 1'b1, 16'hAAAA, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 15'h7FFF, 16'h5555, 1'b0, 15'h7FFF, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 15'h0123, 16'hBEEF, 1'b0, 15'h0123, 1'b0, 16'hBEEF, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 15'h0200, 16'h0001, 1'b1, 15'h0200, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 15'h0201, 16'h0002, 1'b1, 15'h0201, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 15'h0000, 16'h0000, 1'b0, 15'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    host_wr = 1'b1; host_addr = 15'h7777; host_wdata = 16'h7777;
    for (int i = 0; i < 6; i++) begin
      cpu_req = vecs[i].c_req; cpu_wr = vecs[i].c_wr;
      cpu_addr = vecs[i].c_addr; cpu_wdata = vecs[i].c_wdata;
      host_req = vecs[i].h_req;
      @(negedge clk);
      check($sformatf("vec%0d_addr", i), ram_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_wr", i), ram_wr, vecs[i].e_wr);
      check($sformatf("vec%0d_din", i), ram_din, vecs[i].e_din);
      check($sformatf("vec%0d_stall", i), cpu_stall, vecs[i].e_stall);
      check($sformatf("vec%0d_gnt", i), host_gnt, vecs[i].e_gnt);
      tick();
    end
    idle_inputs();
    tick();
    check("vec_mem16", mem[16], 16'hAAAA);
    check("vec_mem512", mem[512], 16'h0001);

    // ---------------- host write 0x1234 to 400, CPU idle ----------------
    host_req = 1'b1; host_wr = 1'b1; host_addr = 15'd400; host_wdata = 16'h1234;
    @(negedge clk);
    check("hw_gnt_c0", host_gnt, 1'b0);
    check("hw_stall_c0", cpu_stall, 1'b0);
    tick();
    @(negedge clk);
    check("hw_gnt_c1", host_gnt, 1'b1);
    check("hw_stall_c1", cpu_stall, 1'b1);
    check("hw_ram_wr", ram_wr, 1'b1);
    check("hw_ram_addr", ram_addr, 15'd400);
    check("hw_ram_din", ram_din, 16'h1234);
    tick();
    host_req = 1'b0; host_wr = 1'b0;
    @(negedge clk);
    check("hw_stall_c2", cpu_stall, 1'b1);
    check("hw_gnt_c2", host_gnt, 1'b0);
    check("hw_mem400", mem[400], 16'h1234);
    tick();
    @(negedge clk);
    check("hw_stall_drain", cpu_stall, 1'b1);
    check("hw_rvalid_write", host_rvalid, 1'b0);
    tick();
    @(negedge clk);
    check("hw_stall_after", cpu_stall, 1'b0);
    tick();

    // ---------------- burst of 6 reads, BURST_MAX=4 ----------------
    for (int i = 0; i < 6; i++) poke(15'(i), 16'(10 + i));
    k = 15'd0; gap = 1'b0;
    host_req = 1'b1; host_wr = 1'b0; host_addr = 15'd0;
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      @(negedge clk);
      if (got.size() >= 4 && got.size() < 6 && !cpu_stall) gap = 1'b1;
      if (host_rvalid) got.push_back(host_rdata);
      if (host_gnt) k = k + 15'd1;
      tick();
      if (k >= 15'd6) host_req = 1'b0;
      else host_addr = k;
    end
    check("burst_count", got.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) check($sformatf("burst_data%0d", i), got[i], 16'(10 + i));
    end
    check("burst_gap", gap, 1'b1);
    idle_inputs();
    repeat (3) tick();

    // ---------------- forced grant after MAX_WAIT busy cycles ----------------
    first = -1;
    host_req = 1'b1; host_wr = 1'b0; host_addr = 15'd5;
    for (int n = 0; n < 30 && first < 0; n++) begin
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 15'(300 + n); cpu_wdata = 16'(n);
      @(negedge clk);
      if (host_gnt) begin
        first = n;
        check("force_ram_addr", ram_addr, 15'd5);
        check("force_ram_wr", ram_wr, 1'b0);
      end
      tick();
    end
    check("force_first_gnt", first, MAX_WAIT + 1);
    check("force_deciding_write", mem[308], 16'd8);
    idle_inputs();
    repeat (3) tick();
    check("force_stalled_write", mem[309] === 16'd9, 1'b0);

    // ---------------- CPU write 256 as host rises, then read back in DRAIN ----------------
    poke(15'd309, 16'h0BAD);
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 15'd256; cpu_wdata = 16'd6;
    host_req = 1'b1; host_wr = 1'b0; host_addr = 15'd253;
    @(negedge clk);
    check("cw_gnt", host_gnt, 1'b0);
    check("cw_ram_wr", ram_wr, 1'b1);
    check("cw_ram_addr", ram_addr, 15'd256);
    tick();
    cpu_req = 1'b0; cpu_wr = 1'b0;
    check("cw_mem256", mem[256], 16'd6);
    grants = 0;
    for (int c = 0; c < 20 && grants < 4; c++) begin
      @(negedge clk);
      if (host_gnt) grants++;
      tick();
      if (grants < 4) host_addr = 15'(253 + grants);
    end
    check("cw_grants", grants, 4);
    host_req = 1'b0;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 15'd256; cpu_wdata = 16'd99;
    @(negedge clk);
    check("drain_stall", cpu_stall, 1'b1);
    check("drain_gnt", host_gnt, 1'b0);
    check("drain_ram_wr", ram_wr, 1'b0);
    check("drain_rvalid", host_rvalid, 1'b1);
    check("drain_rdata", host_rdata, 16'd6);
    @(posedge clk);
    #1;
    idle_inputs();
    check("drain_mem256", mem[256], 16'd6);
    repeat (2) tick();

    // ---------------- reset in the middle of a 3-word read ----------------
    host_req = 1'b1; host_wr = 1'b0; host_addr = 15'd0;
    first = -1;
    for (int c = 0; c < 10 && first < 0; c++) begin
      @(negedge clk);
      if (host_gnt) first = c;
      tick();
    end
    check("mid_first_gnt", first, 1);
    reset = 1'b0;
    host_req = 1'b0;
    #1;
    check("mid_rst_stall", cpu_stall, 1'b0);
    check("mid_rst_gnt", host_gnt, 1'b0);
    check("mid_rst_rvalid", host_rvalid, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    gap = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      if (host_rvalid || cpu_stall) gap = 1'b1;
    end
    check("mid_no_stray", gap, 1'b0);
    tick();

    // ---------------- randomized run against the reference model ----------------
    for (int i = 0; i < 16; i++) begin
      poke(15'(i), 16'($urandom));
      shadow[i] = mem[i];
    end
    m_owner = 0; m_blocked = 0; m_used = 0; m_rv = 1'b0; m_cpu_v = 1'b0;
    m_rd = 16'd0; m_cpu_d = 16'd0;
    last_gnt = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      busy = ((cyc / 200) % 2) == 1;
      cpu_req   = busy ? 1'b1 : ($urandom_range(0, 9) < 7);
      cpu_wr    = 1'($urandom_range(0, 1));
      cpu_addr  = 15'($urandom_range(0, 15));
      cpu_wdata = 16'($urandom);
      if (!(host_req && !last_gnt)) begin
        if ($urandom_range(0, 2) == 0) begin
          host_req   = 1'b1;
          host_wr    = 1'($urandom_range(0, 1));
          host_addr  = 15'($urandom_range(0, 15));
          host_wdata = 16'($urandom);
        end else begin
          host_req = 1'b0;
        end
      end
      @(negedge clk);
      check("rnd_stall", cpu_stall, m_owner != 0);
      check("rnd_gnt", host_gnt, (m_owner == 1) && host_req);
      check("rnd_rvalid", host_rvalid, m_rv);
      if (m_rv) check("rnd_host_rdata", host_rdata, m_rd);
      if (m_cpu_v) check("rnd_cpu_rdata", cpu_rdata, m_cpu_d);
      e_wr = ((m_owner == 0) && cpu_req && cpu_wr) || ((m_owner == 1) && host_req && host_wr);
      check("rnd_ram_wr", ram_wr, e_wr);
      last_gnt = host_gnt;
      m_rv = 1'b0; m_cpu_v = 1'b0;
      if (m_owner == 0) begin
        if (cpu_req) begin
          if (cpu_wr) shadow[cpu_addr[3:0]] = cpu_wdata;
          else begin m_cpu_v = 1'b1; m_cpu_d = shadow[cpu_addr[3:0]]; end
        end
        if (host_req && (!cpu_req || m_blocked >= MAX_WAIT)) begin
          m_owner = 1; m_used = 0; m_blocked = 0;
        end else if (host_req) begin
          m_blocked = (m_blocked < 255) ? m_blocked + 1 : 255;
        end else begin
          m_blocked = 0;
        end
      end else if (m_owner == 1) begin
        if (host_req) begin
          if (host_wr) shadow[host_addr[3:0]] = host_wdata;
          else begin m_rv = 1'b1; m_rd = shadow[host_addr[3:0]]; end
          m_used++;
          if (m_used == BURST_MAX) m_owner = 2;
        end else begin
          m_owner = 2;
        end
      end else begin
        m_owner = 0; m_blocked = 0;
      end
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    for (int i = 0; i < 16; i++) check($sformatf("rnd_mem%0d", i), mem[i], shadow[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
